// File: rtl/cdc_sync_nff_pkg.sv
// cdc_sync_nff_pkg: shared constants and sizing helpers for the cdc_sync_nff synchroniser family
package cdc_sync_nff_pkg;
  localparam int MIN_STAGES = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
  function automatic int cnt_w(input int f);
    return (f < 1) ? 1 : clog2(f + 1);
  endfunction
endpackage

// File: rtl/cdc_sync_filter.sv
// cdc_sync_filter: single-bit glitch filter; q_o takes d_i only after FILTER+1 consecutive disagreeing edges
module cdc_sync_filter
  import cdc_sync_nff_pkg::*;
#(
  parameter int   FILTER    = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic rd_clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  localparam int CW = cnt_w(FILTER);
  localparam logic [CW-1:0] LIMIT = CW'(FILTER);
  logic [CW-1:0] cnt_q, cnt_d;
  logic q_q, q_d, diff, hit;
  // Limit check comes before the increment so the counter can never wrap.
  always_comb begin
    diff  = d_i != q_q;
    hit   = cnt_q == LIMIT;
    cnt_d = (diff && !hit) ? cnt_q + 1'b1 : '0;
    q_d   = (diff && hit) ? d_i : q_q;
  end
  always_ff @(posedge rd_clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      q_q   <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  assign q_o = q_q;
endmodule

// File: rtl/cdc_sync_nff.sv
// cdc_sync_nff: WIDTH independent N-flop level synchronisers with optional glitch filter;
// edge pulses rd_rise/rd_fall are generated only when CDC_SYNC_NFF_EDGE_EN is defined.
module cdc_sync_nff
  import cdc_sync_nff_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter int               FILTER    = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             rd_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wr_p,
  output logic [WIDTH-1:0] rd_p,
  output logic [WIDTH-1:0] rd_rise,
  output logic [WIDTH-1:0] rd_fall
);
  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("cdc_sync_nff: STAGES must be >= 2");
  end
  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] sync_out;
  always_comb sync_d = {sync_q[STAGES-2:0], wr_p};
  always_ff @(posedge rd_clk or negedge rst_n)
    if (!rst_n) sync_q <= {STAGES{RESET_VAL}};
    else sync_q <= sync_d;
  assign sync_out = sync_q[STAGES-1];
  if (FILTER > 0) begin : g_filt
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      cdc_sync_filter #(
        .FILTER   (FILTER),
        .RESET_VAL(RESET_VAL[i])
      ) u_filt (
        .rd_clk(rd_clk),
        .rst_n (rst_n),
        .d_i   (sync_out[i]),
        .q_o   (rd_p[i])
      );
    end
  end else begin : g_nofilt
    assign rd_p = sync_out;
  end
`ifdef CDC_SYNC_NFF_EDGE_EN
  // rd_q resets to RESET_VAL so reset release never produces a pulse.
  logic [WIDTH-1:0] rd_q;
  always_ff @(posedge rd_clk or negedge rst_n)
    if (!rst_n) rd_q <= RESET_VAL;
    else rd_q <= rd_p;
  assign rd_rise = rd_p & ~rd_q;
  assign rd_fall = ~rd_p & rd_q;
`else
  assign rd_rise = '0;
  assign rd_fall = '0;
`endif
endmodule

// File: tb/tb_cdc_sync_nff.sv
// tb_cdc_sync_nff: scoreboard bench for a filtered (S=2,F=3) and an unfiltered (S=3,F=0) instance
module tb_cdc_sync_nff;
`ifdef CDC_SYNC_NFF_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  localparam logic [3:0] RV_A = 4'b0101;
  localparam logic [3:0] RV_B = 4'b0000;
  localparam int S_A = 2, F_A = 3, S_B = 3, F_B = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] wr_a = RV_A, wr_b = RV_B;
  logic [3:0] rd_p_a, rd_rise_a, rd_fall_a, rd_p_b, rd_rise_b, rd_fall_b;
  always #5 clk = ~clk;

  cdc_sync_nff #(.WIDTH(4), .STAGES(S_A), .FILTER(F_A), .RESET_VAL(RV_A)) dut_a (
    .rd_clk(clk), .rst_n(rst_n), .wr_p(wr_a), .rd_p(rd_p_a), .rd_rise(rd_rise_a), .rd_fall(rd_fall_a));
  cdc_sync_nff #(.WIDTH(4), .STAGES(S_B), .FILTER(F_B), .RESET_VAL(RV_B)) dut_b (
    .rd_clk(clk), .rst_n(rst_n), .wr_p(wr_b), .rd_p(rd_p_b), .rd_rise(rd_rise_b), .rd_fall(rd_fall_b));

  typedef struct packed {logic [3:0] pa, ra, fa, pb, rb, fb;} exp_t;
  exp_t exp_q[$];
  logic [3:0] wh_a[$], wh_b[$];
  logic [3:0] rd_a_prev, rd_b_prev;
  int n_edge, n_cmp, n_bad, rise3_cnt, fall3_cnt, hi3_cnt;

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, want, $time);
    end
  endtask

  // synchroniser output after edge k: the wr value captured STAGES-1 edges earlier
  function automatic logic [3:0] sync_at(input logic [3:0] wh[$], input int k, input int s,
                                          input logic [3:0] rv);
    return (k - s >= 0 && k - s < wh.size()) ? wh[k-s] : rv;
  endfunction

  // a bit flips once the synchroniser output has disagreed with it for F+1 straight edges
  function automatic logic [3:0] next_rd(input logic [3:0] wh[$], input logic [3:0] rd_prev,
                                         input int m, input int s, input int f, input logic [3:0] rv);
    logic [3:0] all_diff;
    if (f == 0) return sync_at(wh, m, s, rv);
    all_diff = 4'b1111;
    for (int j = 0; j <= f; j++) all_diff &= sync_at(wh, m - 1 - j, s, rv) ^ rd_prev;
    return rd_prev ^ all_diff;
  endfunction

  task automatic step(input logic [3:0] wa, input logic [3:0] wb);
    exp_t e;
    logic [3:0] ra, rb;
    @(negedge clk);
    wr_a = wa;
    wr_b = wb;
    @(posedge clk);
    n_edge++;
    wh_a.push_back(wa);
    wh_b.push_back(wb);
    ra = next_rd(wh_a, rd_a_prev, n_edge, S_A, F_A, RV_A);
    rb = next_rd(wh_b, rd_b_prev, n_edge, S_B, F_B, RV_B);
    e.pa = ra;
    e.ra = EDGE ? (ra & ~rd_a_prev) : 4'b0000;
    e.fa = EDGE ? (~ra & rd_a_prev) : 4'b0000;
    e.pb = rb;
    e.rb = EDGE ? (rb & ~rd_b_prev) : 4'b0000;
    e.fb = EDGE ? (~rb & rd_b_prev) : 4'b0000;
    exp_q.push_back(e);
    rd_a_prev = ra;
    rd_b_prev = rb;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    wh_a.delete();
    wh_b.delete();
    n_edge = 0;
    rd_a_prev = RV_A;
    rd_b_prev = RV_B;
    #1;
    chk("rst_rd_p_a", rd_p_a, RV_A);
    chk("rst_rd_p_b", rd_p_b, RV_B);
    chk("rst_rise_a", rd_rise_a, 4'b0000);
    chk("rst_fall_a", rd_fall_a, 4'b0000);
    chk("rst_rise_b", rd_rise_b, 4'b0000);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic scen_rise();
    for (int i = 1; i <= 6; i++) begin
      step(4'b0111, 4'b0001);
      #1;
      if (i == 2) chk("b_p_edge2", rd_p_b, 4'b0000);
      if (i == 3) chk("b_p_edge3", rd_p_b, 4'b0001);
      if (i == 5) chk("a_p_edge5", rd_p_a, RV_A);
      if (i == 6) begin
        chk("a_p_edge6", rd_p_a, 4'b0111);
        chk("a_rise_edge6", rd_rise_a, EDGE ? 4'b0010 : 4'b0000);
        chk("a_fall_edge6", rd_fall_a, 4'b0000);
      end
    end
    step(4'b0111, 4'b0001);
    #1 chk("a_rise_edge7", rd_rise_a, 4'b0000);
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_rd_p_a", rd_p_a, e.pa);
      chk("sb_rise_a", rd_rise_a, e.ra);
      chk("sb_fall_a", rd_fall_a, e.fa);
      chk("sb_rd_p_b", rd_p_b, e.pb);
      chk("sb_rise_b", rd_rise_b, e.rb);
      chk("sb_fall_b", rd_fall_b, e.fb);
      rise3_cnt += int'(rd_rise_a[3]);
      fall3_cnt += int'(rd_fall_a[3]);
      hi3_cnt += int'(rd_p_a[3]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] wa, flip;
    n_cmp = 0;
    n_bad = 0;
    do_reset();
    repeat (6) step(RV_A, RV_B);
    #1 chk("post_rst_rise_a", rd_rise_a | rd_fall_a, 4'b0000);
    scen_rise();
    rise3_cnt = 0;
    fall3_cnt = 0;
    hi3_cnt = 0;
    repeat (3) step(4'b1111, 4'b0000);
    repeat (8) step(4'b0111, 4'b0000);
    chk("glitch3_rise3", 4'(rise3_cnt), 4'd0);
    chk("glitch3_hi3", 4'(hi3_cnt), 4'd0);
    repeat (4) step(4'b1111, 4'b0000);
    repeat (10) step(4'b0111, 4'b0000);
    chk("pulse4_rise3", 4'(rise3_cnt), 4'(EDGE));
    chk("pulse4_fall3", 4'(fall3_cnt), 4'(EDGE));
    chk("pulse4_seen_hi", 4'(hi3_cnt > 0), 4'd1);
    do_reset();
    repeat (4) step(4'b0111, 4'b0000);
    do_reset();
    scen_rise();
    wa = wr_a;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 3) == 0);
      wa ^= flip;
      step(wa, 4'($urandom));
    end
    @(negedge clk);
    #1 chk("sb_drained", 4'(exp_q.size()), 4'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
